// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tft_pkg
// Description : Shared definitions for the TFT sprite path: display command
//               bytes, blitter FSM state encoding and the RGB565 pixel type.
// Revision    : 1.0 - initial release
// ============================================================================
package tft_pkg;

    // Display controller commands
    localparam logic [7:0] c_caset = 8'h2A;  // column address set
    localparam logic [7:0] c_paset = 8'h2B;  // page (row) address set
    localparam logic [7:0] c_ramwr = 8'h2C;  // memory write

    // Blitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PIX  = 2'd2
    } tft_state_e;

    // One RGB565 pixel
    typedef logic [15:0] rgb565_t;

endpackage : tft_pkg
`default_nettype wire

// File: rtl/sprite_rom.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom
// Description : Combinational 1-bit-per-pixel sprite bitmap, indexed by
//               animation frame, row and column. The shape is a top bar, a
//               vertical bar at column == frame, and a half-width bottom bar;
//               it is deliberately asymmetric so every orientation differs.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom
    import tft_pkg::*;
#(
    parameter int SIZE   = 22,
    parameter int FRAMES = 3,
    localparam int RC_W  = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int FR_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic [FR_W-1:0] i_frame,
    input  logic [RC_W-1:0] i_row,
    input  logic [RC_W-1:0] i_col,
    output logic            o_pixel
);

    // Bitmap lookup
    always_comb begin
        o_pixel = (int'(i_row) == 0)
               || (int'(i_col) == int'(i_frame))
               || ((int'(i_row) == SIZE - 1) && (int'(i_col) < SIZE / 2));
    end

endmodule : sprite_rom
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : Draws a square sprite onto a TFT panel over a byte-wide
//               command/data link. A move first erases the part of the old
//               box left uncovered, then opens the sprite window and streams
//               RGB565 pixels with the chosen frame and orientation.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
    import tft_pkg::*;
#(
    parameter int          SIZE     = 22,
    parameter int          COORD_W  = 9,
    parameter int          FRAMES   = 3,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    localparam int         FR_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int         RC_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               draw,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [FR_W-1:0]    frame,
    input  logic [1:0]         dir,
    input  logic               tft_busy,
    output logic               tft_transmit,
    output logic               tft_dc,
    output logic [7:0]         tft_data,
    output logic               busy,
    output logic               reject
);

    // One spare bit so box ends and differences never wrap
    localparam int             CW        = COORD_W + 1;
    localparam logic [CW-1:0]  c_size    = CW'(SIZE);
    localparam logic [CW-1:0]  c_size_m1 = CW'(SIZE - 1);
    localparam logic [CW-1:0]  c_lim     = CW'((1 << COORD_W) - SIZE);
    localparam logic [RC_W-1:0] c_last_rc = RC_W'(SIZE - 1);

    tft_state_e      r_state;
    logic            r_erase;
    logic [3:0]      r_idx;
    logic [CW-1:0]   r_col, r_row;
    logic            r_half;
    logic [CW-1:0]   r_wx0, r_wx1, r_wy0, r_wy1;
    logic [CW-1:0]   r_xn, r_yn, r_xo, r_yo;
    logic            r_valid;
    logic [FR_W-1:0] r_frame;
    logic [1:0]      r_dir;
    logic            r_transmit, r_dc, r_reject;
    logic [7:0]      r_data;

    logic [CW-1:0]   w_xi, w_yi;
    logic            w_oob, w_accept, w_reject_req, w_issue;
    logic            w_has_erase;
    logic [CW-1:0]   w_ex0, w_ex1, w_ey0, w_ey1;
    logic [CW-1:0]   w_coord;
    logic [15:0]     w_cext;
    logic            w_dc;
    logic [7:0]      w_byte;
    logic [RC_W-1:0] w_rr, w_rc;
    logic            w_pix;
    rgb565_t         w_color;
    logic            w_win_last, w_col_last, w_row_last;

    assign w_xi         = {1'b0, x};
    assign w_yi         = {1'b0, y};
    assign w_oob        = (w_xi > c_lim) || (w_yi > c_lim);
    assign w_accept     = enable && !busy && draw && !w_oob;
    assign w_reject_req = enable && !busy && draw && w_oob;
    assign w_issue      = enable && !tft_busy && !r_transmit && (r_state != ST_IDLE);
    assign w_win_last   = (r_idx == 4'd10);
    assign w_col_last   = (r_col == (r_wx1 - r_wx0));
    assign w_row_last   = (r_row == (r_wy1 - r_wy0));

    // Erase region: uncovered strip for short horizontal/vertical moves, else whole old box
    always_comb begin
        w_has_erase = 1'b0;
        w_ex0       = r_xo;
        w_ex1       = r_xo + c_size_m1;
        w_ey0       = r_yo;
        w_ey1       = r_yo + c_size_m1;
        if (r_valid && !((w_xi == r_xo) && (w_yi == r_yo))) begin
            w_has_erase = 1'b1;
            if ((w_yi == r_yo) && (w_xi > r_xo) && ((w_xi - r_xo) < c_size)) begin
                w_ex1 = w_xi - CW'(1);
            end else if ((w_yi == r_yo) && (w_xi < r_xo) && ((r_xo - w_xi) < c_size)) begin
                w_ex0 = w_xi + c_size;
            end else if ((w_xi == r_xo) && (w_yi > r_yo) && ((w_yi - r_yo) < c_size)) begin
                w_ey1 = w_yi - CW'(1);
            end else if ((w_xi == r_xo) && (w_yi < r_yo) && ((r_yo - w_yi) < c_size)) begin
                w_ey0 = w_yi + c_size;
            end
        end
    end

    // Orientation: map window (row, col) to bitmap (row, col)
    always_comb begin
        case (r_dir)
            2'd0: begin w_rr = r_row[RC_W-1:0]; w_rc = r_col[RC_W-1:0]; end
            2'd1: begin w_rr = r_row[RC_W-1:0]; w_rc = c_last_rc - r_col[RC_W-1:0]; end
            2'd2: begin w_rr = r_col[RC_W-1:0]; w_rc = r_row[RC_W-1:0]; end
            default: begin w_rr = r_col[RC_W-1:0]; w_rc = c_last_rc - r_row[RC_W-1:0]; end
        endcase
    end

    sprite_rom #(
        .SIZE   (SIZE),
        .FRAMES (FRAMES)
    ) u_rom (
        .i_frame (r_frame),
        .i_row   (w_rr),
        .i_col   (w_rc),
        .o_pixel (w_pix)
    );

    // Next byte to send: window command sequence or pixel half
    always_comb begin
        w_color = r_erase ? BG_COLOR : (w_pix ? FG_COLOR : BG_COLOR);
        case (r_idx)
            4'd1, 4'd2: w_coord = r_wx0;
            4'd3, 4'd4: w_coord = r_wx1;
            4'd6, 4'd7: w_coord = r_wy0;
            default:    w_coord = r_wy1;
        endcase
        w_cext = 16'(w_coord);
        w_dc   = 1'b1;
        w_byte = r_half ? w_color[7:0] : w_color[15:8];
        if (r_state == ST_WIN) begin
            case (r_idx)
                4'd0:                      begin w_dc = 1'b0; w_byte = c_caset; end
                4'd5:                      begin w_dc = 1'b0; w_byte = c_paset; end
                4'd10:                     begin w_dc = 1'b0; w_byte = c_ramwr; end
                4'd1, 4'd3, 4'd6, 4'd8:    w_byte = w_cext[15:8];
                default:                   w_byte = w_cext[7:0];
            endcase
        end
    end

    // Request handling, byte sequencing and pass control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_erase    <= 1'b0;
            r_idx      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_half     <= 1'b0;
            r_wx0      <= '0;
            r_wx1      <= '0;
            r_wy0      <= '0;
            r_wy1      <= '0;
            r_xn       <= '0;
            r_yn       <= '0;
            r_xo       <= '0;
            r_yo       <= '0;
            r_valid    <= 1'b0;
            r_frame    <= '0;
            r_dir      <= '0;
            r_transmit <= 1'b0;
            r_dc       <= 1'b0;
            r_data     <= '0;
            r_reject   <= 1'b0;
        end else if (enable) begin
            r_transmit <= w_issue;
            r_reject   <= w_reject_req;
            if (w_accept) begin
                r_xn    <= w_xi;
                r_yn    <= w_yi;
                r_frame <= frame;
                r_dir   <= dir;
                r_idx   <= '0;
                r_state <= ST_WIN;
                r_erase <= w_has_erase;
                if (w_has_erase) begin
                    r_wx0 <= w_ex0;
                    r_wx1 <= w_ex1;
                    r_wy0 <= w_ey0;
                    r_wy1 <= w_ey1;
                end else begin
                    r_wx0 <= w_xi;
                    r_wx1 <= w_xi + c_size_m1;
                    r_wy0 <= w_yi;
                    r_wy1 <= w_yi + c_size_m1;
                end
            end
            if (w_issue) begin
                r_dc   <= w_dc;
                r_data <= w_byte;
                if (r_state == ST_WIN) begin
                    if (w_win_last) begin
                        r_state <= ST_PIX;
                        r_idx   <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_half  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end else begin
                    r_half <= ~r_half;
                    if (r_half) begin
                        if (!w_col_last) begin
                            r_col <= r_col + CW'(1);
                        end else begin
                            r_col <= '0;
                            if (!w_row_last) begin
                                r_row <= r_row + CW'(1);
                            end else begin
                                r_row <= '0;
                                if (r_erase) begin
                                    r_erase <= 1'b0;
                                    r_state <= ST_WIN;
                                    r_wx0   <= r_xn;
                                    r_wx1   <= r_xn + c_size_m1;
                                    r_wy0   <= r_yn;
                                    r_wy1   <= r_yn + c_size_m1;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_xo    <= r_xn;
                                    r_yo    <= r_yn;
                                    r_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end else begin
            r_transmit <= 1'b0;
            r_reject   <= 1'b0;
        end
    end

    // Busy covers the strobe cycle of the final byte
    assign busy         = (r_state != ST_IDLE) || r_transmit;
    assign reject       = r_reject;
    assign tft_transmit = r_transmit;
    assign tft_dc       = r_dc;
    assign tft_data     = r_data;

endmodule : sprite_blitter
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Directed self-checking bench for sprite_blitter. Captured
//               byte streams are compared with streams built from hand-chosen
//               windows and a small model of the bitmap and orientation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    localparam int SIZE    = 22;
    localparam int COORD_W = 9;
    localparam int FRAMES  = 3;

    logic       clk = 1'b0;
    logic       rst, enable, draw, tft_busy;
    logic [8:0] x, y;
    logic [1:0] frame, dir;
    logic       tft_transmit, tft_dc, busy, reject;
    logic [7:0] tft_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_double = 0;
    logic       prev_tx = 1'b0;
    logic [8:0] cap[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    sprite_blitter #(
        .SIZE     (SIZE),
        .COORD_W  (COORD_W),
        .FRAMES   (FRAMES),
        .FG_COLOR (16'hFFFF),
        .BG_COLOR (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .draw         (draw),
        .x            (x),
        .y            (y),
        .frame        (frame),
        .dir          (dir),
        .tft_busy     (tft_busy),
        .tft_transmit (tft_transmit),
        .tft_dc       (tft_dc),
        .tft_data     (tft_data),
        .busy         (busy),
        .reject       (reject)
    );

    // Capture every strobed byte as {dc, data}; flag back-to-back strobes
    always @(negedge clk) begin
        if (tft_transmit) begin
            cap.push_back({tft_dc, tft_data});
            if (prev_tx) n_double++;
        end
        prev_tx = tft_transmit;
    end

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic bit rom_bit(input int f, input int r, input int c);
        return (r == 0) || (c == f) || ((r == SIZE - 1) && (c < SIZE / 2));
    endfunction

    function automatic void push_c(input int b);
        exp_q.push_back(9'(b & 255));
    endfunction

    function automatic void push_d(input int b);
        exp_q.push_back(9'(256 + (b & 255)));
    endfunction

    function automatic void push_win(input int x0, input int x1, input int y0, input int y1);
        push_c(8'h2A); push_d(x0 >> 8); push_d(x0); push_d(x1 >> 8); push_d(x1);
        push_c(8'h2B); push_d(y0 >> 8); push_d(y0); push_d(y1 >> 8); push_d(y1);
        push_c(8'h2C);
    endfunction

    function automatic void push_erase(input int x0, input int x1, input int y0, input int y1);
        push_win(x0, x1, y0, y1);
        for (int n = 0; n < (x1 - x0 + 1) * (y1 - y0 + 1) * 2; n++) push_d(0);
    endfunction

    function automatic void push_sprite(input int px, input int py, input int f, input int d);
        int rr, cc, v;
        push_win(px, px + SIZE - 1, py, py + SIZE - 1);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                case (d)
                    0: begin rr = r; cc = c; end
                    1: begin rr = r; cc = SIZE - 1 - c; end
                    2: begin rr = c; cc = r; end
                    default: begin rr = c; cc = SIZE - 1 - r; end
                endcase
                v = rom_bit(f, rr, cc) ? 255 : 0;
                push_d(v);
                push_d(v);
            end
        end
    endfunction

    task automatic compare(input string tag);
        int nmis = 0;
        chk({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) nmis++;
        chk({tag, "_bytes"}, nmis, 0);
    endtask

    // Issue one draw and wait for completion, with optional stall, freeze and busy-time poke
    task automatic do_draw(input string tag, input int xx, input int yy, input int f, input int d,
                           input int stall_at, input int freeze_at, input bit poke);
        int  n0;
        bit  done = 1'b0;
        int  st   = stall_at;
        int  fz   = freeze_at;
        cap.delete();
        @(posedge clk); #1;
        x = 9'(xx); y = 9'(yy); frame = 2'(f); dir = 2'(d); draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (poke && i == 5) begin draw = 1'b1; x = 9'd500; y = 9'd3; end
            if (poke && i == 6) begin draw = 1'b0; chk({tag, "_no_reject"}, reject, 0); end
            if (st > 0 && cap.size() >= st) begin
                st = 0;
                tft_busy = 1'b1;
                @(posedge clk); #1;
                n0 = cap.size();
                repeat (49) @(posedge clk);
                #1;
                chk({tag, "_stall_hold"}, cap.size(), n0);
                tft_busy = 1'b0;
            end
            if (fz > 0 && cap.size() >= fz) begin
                fz = 0;
                enable = 1'b0;
                @(posedge clk); #1;
                n0 = cap.size();
                repeat (20) @(posedge clk);
                #1;
                chk({tag, "_freeze_hold"}, cap.size(), n0);
                chk({tag, "_freeze_busy"}, busy, 1);
                chk({tag, "_freeze_tx"}, tft_transmit, 0);
                enable = 1'b1;
            end
            if (!busy) begin done = 1'b1; break; end
        end
        chk({tag, "_done"}, done, 1);
    endtask

    logic [8:0] win_a[11];

    initial begin
        int n0;
        bit hit;
        rst = 1'b1; enable = 1'b1; draw = 1'b0; tft_busy = 1'b0;
        x = '0; y = '0; frame = '0; dir = '0;
        win_a = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h11A,
                  9'h02B, 9'h100, 9'h105, 9'h100, 9'h11A, 9'h02C};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_reject", reject, 0);
        chk("rst_tx", tft_transmit, 0);
        chk("rst_dc", tft_dc, 0);
        chk("rst_data", tft_data, 0);
        rst = 1'b0;

        // First draw: no erase
        do_draw("a", 5, 5, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 11; i++) chk($sformatf("a_win%0d", i), cap[i], win_a[i]);
        exp_q.delete(); push_sprite(5, 5, 0, 0); compare("a");

        // Short move right: left strip erase, with a clock-enable freeze
        do_draw("b", 8, 5, 0, 0, 0, 60, 1'b0);
        exp_q.delete(); push_erase(5, 7, 5, 26); push_sprite(8, 5, 0, 0); compare("b");

        // Far move: full erase, link stall mid-pixel
        do_draw("c", 40, 40, 1, 1, 1500, 0, 1'b0);
        exp_q.delete(); push_erase(8, 29, 5, 26); push_sprite(40, 40, 1, 1); compare("c");

        // Out-of-range request
        cap.delete();
        @(posedge clk); #1;
        x = 9'd491; y = 9'd0; draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        chk("d_reject", reject, 1);
        chk("d_busy", busy, 0);
        @(posedge clk); #1;
        chk("d_reject_pulse", reject, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("d_no_strobe", cap.size(), 0);

        // Short move right from unchanged old position, with a draw while busy
        do_draw("e", 50, 40, 2, 2, 0, 0, 1'b1);
        exp_q.delete(); push_erase(40, 49, 40, 61); push_sprite(50, 40, 2, 2); compare("e");

        // Short move down
        do_draw("f", 50, 60, 0, 3, 0, 0, 1'b0);
        exp_q.delete(); push_erase(50, 71, 40, 59); push_sprite(50, 60, 0, 3); compare("f");

        // Short move left: right strip erase
        do_draw("g", 45, 60, 1, 0, 0, 0, 1'b0);
        exp_q.delete(); push_erase(67, 71, 60, 81); push_sprite(45, 60, 1, 0); compare("g");

        // Largest legal position
        do_draw("h", 490, 490, 2, 1, 0, 0, 1'b0);
        exp_q.delete(); push_erase(45, 66, 60, 81); push_sprite(490, 490, 2, 1); compare("h");
        chk("h_xmin_hi", cap[980], 9'h101);
        chk("h_xmin_lo", cap[981], 9'h1EA);
        chk("h_xmax_lo", cap[983], 9'h1FF);

        // Same position again: no erase
        do_draw("i", 490, 490, 0, 2, 0, 0, 1'b0);
        exp_q.delete(); push_sprite(490, 490, 0, 2); compare("i");

        // Reset in the middle of the sprite pixels
        cap.delete();
        @(posedge clk); #1;
        x = 9'd100; y = 9'd100; frame = 2'd1; dir = 2'd0; draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (cap.size() >= 1200) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("j_reach_pix", hit, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("j_busy", busy, 0);
        chk("j_reject", reject, 0);
        chk("j_tx", tft_transmit, 0);
        chk("j_dc", tft_dc, 0);
        chk("j_data", tft_data, 0);
        rst = 1'b0;
        n0 = cap.size();
        repeat (10) @(posedge clk);
        #1;
        chk("j_quiet", cap.size(), n0);

        // After reset the old position is forgotten
        do_draw("k", 5, 5, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 11; i++) chk($sformatf("k_win%0d", i), cap[i], win_a[i]);
        exp_q.delete(); push_sprite(5, 5, 0, 0); compare("k");

        chk("double_strobe", n_double, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sprite_blitter
`default_nettype wire
